// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl_pkg
// Description : Shared stall/flush definitions for the GeMIPS pipeline
//               (the pipe_ctrl_defs set): FSM state encodings, stage bit
//               indices and the per-stage stall vector constants.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

  // Wait-tracking FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_EX_WAIT  = 2'd2
  } state_t;

  // Bit position of each stage register in the stall vector
  typedef enum int unsigned {
    STG_PC  = 0,
    STG_IF  = 1,
    STG_ID  = 2,
    STG_EX  = 3,
    STG_MEM = 4,
    STG_WB  = 5
  } stage_e;

  localparam int unsigned STALL_W = 6;

  // A stall freezes its source stage and everything upstream of it;
  // the first downstream stage left running receives a bubble.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'((1 << STG_PC) | (1 << STG_IF) | (1 << STG_ID));
  localparam logic [STALL_W-1:0] STALL_EX   = STALL_ID | 6'(1 << STG_EX);
  localparam logic [STALL_W-1:0] STALL_MEM  = STALL_EX | 6'(1 << STG_MEM);

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl_if
// Description : Request/response bundle between the pipeline stages
//               (master) and the stall/flush scheduler (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stall_ctrl_if;
  import pipe_stall_ctrl_pkg::*;

  logic                id_stall_req;
  logic                ex_stall_req;
  logic                ex_done;
  logic                mem_stall_req;
  logic                mem_done;
  logic                branch_flush;
  logic [STALL_W-1:0]  stall;
  logic                flush_ifid;
  logic                flush_idex;
  logic                busy;
  logic                timeout_err;
  logic [31:0]         stall_cycles;

  // Pipeline side: raises requests, obeys stall/flush
  modport master (
    output id_stall_req, ex_stall_req, ex_done, mem_stall_req, mem_done, branch_flush,
    input  stall, flush_ifid, flush_idex, busy, timeout_err, stall_cycles
  );

  // Scheduler side
  modport slave (
    input  id_stall_req, ex_stall_req, ex_done, mem_stall_req, mem_done, branch_flush,
    output stall, flush_ifid, flush_idex, busy, timeout_err, stall_cycles
  );

endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl_wait_timer
// Description : Wait-state cycle counter with synchronous clear, count
//               enable and a terminal-count flag at MEM_TIMEOUT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 32,
  parameter int CNT_W       = 6
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic             enable,
  output logic [CNT_W-1:0]      cnt,
  output logic                  tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MEM_TIMEOUT - 1);

  // Clear wins over enable so a fresh state always starts counting at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Central stall/flush scheduler for the 5-stage GeMIPS
//               pipeline. Arbitrates MEM > EX > ID stall requests, drives
//               the per-stage stall vector and IF/ID, ID/EX flush strobes,
//               and guards long waits with a timeout.
//               Optional macro STALL_PERF_CNT_EN enables the stall_cycles
//               performance counter (tied to zero otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 32,
  parameter int CNT_W       = 6
) (
  input  wire logic     clk,
  input  wire logic     rst,
  pipe_stall_ctrl_if.slave bus
);

  state_t              state;
  state_t              next_state;
  logic                ex_done_q;
  logic                timeout_err_q;
  logic                busy_q;
  logic [CNT_W-1:0]    cnt;
  logic                tc;
  logic [STALL_W-1:0]  stall_c;
  logic                flush_idex_c;
  logic                timeout_hit;
  logic [STALL_W-1:0]  stall_o;

  // Stall decision and next state; zero-latency from state and requests
  always_comb begin
    next_state   = state;
    stall_c      = STALL_NONE;
    flush_idex_c = 1'b0;
    timeout_hit  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.mem_stall_req && !bus.mem_done) begin
          stall_c    = STALL_MEM;
          next_state = ST_MEM_WAIT;
        end else if (bus.ex_stall_req && !bus.ex_done) begin
          stall_c    = STALL_EX;
          next_state = ST_EX_WAIT;
        end else if (bus.id_stall_req) begin
          // One-cycle bubble; the hazard clears once it advances
          stall_c      = STALL_ID;
          flush_idex_c = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.mem_done) begin
          if (tc) begin
            timeout_hit = 1'b1;
            next_state  = ST_IDLE;
          end else begin
            stall_c = STALL_MEM;
          end
        end else begin
          // Same-cycle release: EX only re-stalls if its done has not already
          // been seen while it was frozen behind MEM
          next_state = ST_IDLE;
          if (bus.ex_stall_req && !bus.ex_done && !ex_done_q) begin
            stall_c    = STALL_EX;
            next_state = ST_EX_WAIT;
          end else if (bus.id_stall_req) begin
            stall_c      = STALL_ID;
            flush_idex_c = 1'b1;
          end
        end
      end
      ST_EX_WAIT: begin
        if (!bus.ex_done) begin
          // ID is already frozen here, so its hazard needs no extra action
          if (tc) begin
            timeout_hit = 1'b1;
            next_state  = ST_IDLE;
          end else begin
            stall_c = STALL_EX;
          end
        end else begin
          next_state = ST_IDLE;
          if (bus.mem_stall_req && !bus.mem_done) begin
            stall_c    = STALL_MEM;
            next_state = ST_MEM_WAIT;
          end else if (bus.id_stall_req) begin
            stall_c      = STALL_ID;
            flush_idex_c = 1'b1;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state, captured EX completion, sticky timeout flag and busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      ex_done_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != ST_IDLE);
      if (state == ST_MEM_WAIT && next_state != ST_MEM_WAIT) begin
        ex_done_q <= 1'b0;
      end else if (state == ST_MEM_WAIT && bus.ex_done) begin
        ex_done_q <= 1'b1;
      end
      if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  pipe_stall_ctrl_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (next_state != state),
    .enable (state != ST_IDLE),
    .cnt    (cnt),
    .tc     (tc)
  );

  // Outputs are forced quiet while reset is held, even with requests pending
  assign stall_o         = rst ? STALL_NONE : stall_c;
  assign bus.stall       = stall_o;
  assign bus.flush_idex  = !rst && flush_idex_c;
  // A branch flush is deferred while ID is held; the branch re-asserts it
  assign bus.flush_ifid  = !rst && bus.branch_flush && !stall_o[STG_ID];
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_q;

  // Count every cycle in which the PC is held; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
    end else if (stall_o[STG_PC]) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Directed self-checking bench for pipe_stall_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(
    .MEM_TIMEOUT (32),
    .CNT_W       (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef STALL_PERF_CNT_EN
  localparam logic [31:0] EXP_PERF = 32'd32;
`else
  localparam logic [31:0] EXP_PERF = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply this cycle's inputs, then let combinational outputs settle
  task automatic drive(input logic id, input logic ex, input logic exd,
                       input logic mem, input logic memd, input logic br);
    bus.id_stall_req  = id;
    bus.ex_stall_req  = ex;
    bus.ex_done       = exd;
    bus.mem_stall_req = mem;
    bus.mem_done      = memd;
    bus.branch_flush  = br;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) cyc();

    // Reset state
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_flush_idex", 32'(bus.flush_idex), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    chk("rst_perf", bus.stall_cycles, 32'd0);
    rst = 1'b0;

    // Load-use: single-cycle ID stall with ID/EX bubble
    cyc(); drive(1, 0, 0, 0, 0, 0);
    chk("lu_stall", 32'(bus.stall), 32'h07);
    chk("lu_flush_idex", 32'(bus.flush_idex), 32'd1);
    chk("lu_busy", 32'(bus.busy), 32'd0);
    cyc(); drive(0, 0, 0, 0, 0, 0);
    chk("lu_stall_after", 32'(bus.stall), 32'd0);
    chk("lu_flush_after", 32'(bus.flush_idex), 32'd0);
    chk("lu_busy_after", 32'(bus.busy), 32'd0);

    // Load wait: mem request cycles 1-5, done in cycle 5
    cyc(); drive(0, 0, 0, 1, 0, 0);
    chk("lw_c1_stall", 32'(bus.stall), 32'h1F);
    chk("lw_c1_busy", 32'(bus.busy), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      cyc(); drive(0, 0, 0, 1, 0, 0);
      chk("lw_mid_stall", 32'(bus.stall), 32'h1F);
      chk("lw_mid_busy", 32'(bus.busy), 32'd1);
    end
    cyc(); drive(0, 0, 0, 1, 1, 0);
    chk("lw_c5_stall", 32'(bus.stall), 32'd0);
    chk("lw_c5_busy", 32'(bus.busy), 32'd1);
    cyc(); drive(0, 0, 0, 0, 0, 0);
    chk("lw_c6_busy", 32'(bus.busy), 32'd0);

    // Overlap: ex_done seen while frozen behind MEM; no EX_WAIT afterwards
    cyc(); drive(0, 1, 0, 1, 0, 0);
    chk("ov_c1_stall", 32'(bus.stall), 32'h1F);
    cyc(); drive(0, 1, 1, 1, 0, 0);
    chk("ov_c2_stall", 32'(bus.stall), 32'h1F);
    cyc(); drive(0, 1, 0, 1, 0, 0);
    chk("ov_c3_stall", 32'(bus.stall), 32'h1F);
    cyc(); drive(0, 1, 0, 1, 1, 0);
    chk("ov_c4_stall", 32'(bus.stall), 32'd0);
    cyc(); drive(0, 0, 0, 0, 0, 0);
    chk("ov_c5_busy", 32'(bus.busy), 32'd0);
    chk("ov_c5_stall", 32'(bus.stall), 32'd0);

    // EX wait, EX beats ID, ID ignored while waiting
    cyc(); drive(1, 1, 0, 0, 0, 0);
    chk("ex_c1_stall", 32'(bus.stall), 32'h0F);
    chk("ex_c1_flush_idex", 32'(bus.flush_idex), 32'd0);
    cyc(); drive(1, 1, 0, 0, 0, 0);
    chk("ex_c2_stall", 32'(bus.stall), 32'h0F);
    chk("ex_c2_flush_idex", 32'(bus.flush_idex), 32'd0);
    chk("ex_c2_busy", 32'(bus.busy), 32'd1);
    cyc(); drive(0, 1, 1, 0, 0, 0);
    chk("ex_c3_stall", 32'(bus.stall), 32'd0);
    cyc(); drive(0, 0, 0, 0, 0, 0);
    chk("ex_c4_busy", 32'(bus.busy), 32'd0);

    // Request together with its own done: no stall, no wait
    cyc(); drive(0, 0, 0, 1, 1, 0);
    chk("sd_stall", 32'(bus.stall), 32'd0);
    cyc(); drive(0, 0, 0, 0, 0, 0);
    chk("sd_busy", 32'(bus.busy), 32'd0);

    // Branch under ID stall is deferred, then taken
    cyc(); drive(1, 0, 0, 0, 0, 1);
    chk("br_c1_stall", 32'(bus.stall), 32'h07);
    chk("br_c1_flush_ifid", 32'(bus.flush_ifid), 32'd0);
    cyc(); drive(0, 0, 0, 0, 0, 1);
    chk("br_c2_flush_ifid", 32'(bus.flush_ifid), 32'd1);
    cyc(); drive(0, 0, 0, 0, 0, 0);
    chk("br_c3_flush_ifid", 32'(bus.flush_ifid), 32'd0);

    // Reset mid MEM_WAIT with the request still pending
    cyc(); drive(0, 0, 0, 1, 0, 1);
    cyc(); drive(0, 0, 0, 1, 0, 1);
    chk("rm_busy_pre", 32'(bus.busy), 32'd1);
    cyc(); rst = 1'b1; #1;
    chk("rm_stall", 32'(bus.stall), 32'd0);
    chk("rm_flush_ifid", 32'(bus.flush_ifid), 32'd0);
    chk("rm_busy", 32'(bus.busy), 32'd0);
    chk("rm_perf", bus.stall_cycles, 32'd0);
    cyc(); rst = 1'b0; drive(0, 0, 0, 0, 0, 0);
    cyc(); drive(0, 0, 0, 0, 0, 0);
    chk("rm_busy_post", 32'(bus.busy), 32'd0);

    // Timeout: mem_done never arrives
    cyc(); drive(0, 0, 0, 1, 0, 0);
    chk("to_c1_stall", 32'(bus.stall), 32'h1F);
    for (int i = 2; i <= 32; i++) begin
      cyc(); drive(0, 0, 0, 1, 0, 0);
    end
    chk("to_c32_stall", 32'(bus.stall), 32'h1F);
    chk("to_c32_err", 32'(bus.timeout_err), 32'd0);
    cyc(); drive(0, 0, 0, 1, 0, 0);
    chk("to_c33_stall", 32'(bus.stall), 32'd0);
    chk("to_c33_busy", 32'(bus.busy), 32'd1);
    cyc(); drive(0, 0, 0, 0, 0, 0);
    chk("to_c34_err", 32'(bus.timeout_err), 32'd1);
    chk("to_c34_busy", 32'(bus.busy), 32'd0);
    chk("to_perf", bus.stall_cycles, EXP_PERF);
    cyc(); drive(1, 0, 0, 0, 0, 0);
    chk("to_sticky", 32'(bus.timeout_err), 32'd1);
    chk("to_lu_stall", 32'(bus.stall), 32'h07);
    cyc(); drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1; #1;
    chk("to_rst_clear", 32'(bus.timeout_err), 32'd0);
    cyc(); rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
